audio_clk_gen: RTL

AUDIO_CLK_GEN -- requirements
Module: audio_clk_gen

---
 rtl/audio_clk_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/audio_clk_gen.sv
// Audio clock generator: NCO-derived BCLK, frame counter, LRCLK word select and lock indication.
// Define AUDIO_CLK_GEN_DSP_FSYNC_EN for a one-BCLK frame-sync pulse instead of a 50% LRCLK.
module audio_clk_gen #(
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned SLOTS       = 2,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned LOCK_FRAMES = 4
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] incr,
  output logic             bclk,
  output logic             lrclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             frame_start,
  output logic             locked
);

  localparam int unsigned Bits = SLOTS * SLOT_W;
  localparam int unsigned CntW = $clog2(Bits);
  localparam int unsigned FrmW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(Bits - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Bits / 2);
  localparam logic [FrmW-1:0] FrmLock = FrmW'(LOCK_FRAMES);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_act_q, inc_act_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             en_q, en_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [FrmW-1:0]  frm_q, frm_d;
  logic             locked_q, locked_d;
  logic [ACC_W:0]   sum;
  logic             carry;

  always_comb begin
    acc_d      = acc_q;
    inc_act_d  = inc_act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    en_d       = enable;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    fs_d       = 1'b0;
    cnt_d      = cnt_q;
    frm_d      = frm_q;
    locked_d   = locked_q;
    sum        = {1'b0, acc_q} + {1'b0, inc_act_q};
    carry      = 1'b0;

    if (!enable) begin
      acc_d      = '0;
      bclk_d     = 1'b0;
      lrclk_d    = 1'b0;
      cnt_d      = '0;
      pend_d     = '0;
      pend_vld_d = 1'b0;
      frm_d      = '0;
      locked_d   = 1'b0;
    end else if (!en_q) begin
      // Enable rising edge: take the frequency word, start accumulating next cycle.
      inc_act_d  = incr;
      pend_vld_d = 1'b0;
    end else begin
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
      if (carry) begin
        bclk_d = ~bclk_q;
        rise_d = ~bclk_q;
        fall_d = bclk_q;
      end
      if (carry && bclk_q) begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        fs_d  = (cnt_q == CntMax);
`ifdef AUDIO_CLK_GEN_DSP_FSYNC_EN
        lrclk_d = (cnt_d == '0);
`else
        lrclk_d = (cnt_d >= CntHalf);
`endif
      end

      if (fs_d && pend_vld_q) begin
        // Retune only on a frame boundary so no frame is built from two rates.
        inc_act_d  = pend_q;
        pend_vld_d = 1'b0;
        frm_d      = '0;
      end else begin
        pend_d     = incr;
        pend_vld_d = (incr != inc_act_q);
        if (inc_act_q == '0) begin
          frm_d = '0;
        end else if (fs_d && (frm_q != FrmLock)) begin
          frm_d = frm_q + FrmW'(1);
        end
      end
      locked_d = (frm_d == FrmLock);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      inc_act_q  <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      en_q       <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      fs_q       <= 1'b0;
      cnt_q      <= '0;
      frm_q      <= '0;
      locked_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_act_q  <= inc_act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      en_q       <= en_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      fs_q       <= fs_d;
      cnt_q      <= cnt_d;
      frm_q      <= frm_d;
      locked_q   <= locked_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;

endmodule
